// File: rtl/alu_cmd_sequencer_if.sv
// Command/response stream bundle between a control master and the ALU sequencer.
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [OPW-1:0]   cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [OPW-1:0]   rsp_op;
  logic             rsp_div0;

  // Control master: issues commands, consumes responses
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_op, rsp_div0
  );

  // Sequencer: accepts commands, produces responses
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_op, rsp_div0
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Drives the SimpleALU: writes the opcode config register only when the opcode
// changes, presents operands for one cycle, captures the result and returns it.
// Divide-by-zero is answered locally without touching the ALU.
module alu_cmd_sequencer #(
  parameter int WIDTH = 16,
  parameter int OPW   = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  alu_cmd_sequencer_if.slave  bus,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [OPW-1:0]      alu_config_data,
  output logic                alu_config_en,
  input  logic [WIDTH-1:0]    alu_c
);

  localparam logic [OPW-1:0] OP_DIV = OPW'(3);

  typedef enum logic [1:0] {IDLE, CONFIG, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [OPW-1:0]   cur_op_q, cur_op_d;     // shadow of the ALU opcode register
  logic             cfg_known_q, cfg_known_d;  // shadow valid since last reset
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [OPW-1:0]   rsp_op_q, rsp_op_d;
  logic             rsp_div0_q, rsp_div0_d;

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      cur_op_q    <= '0;
      cfg_known_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      rsp_data_q  <= '0;
      rsp_op_q    <= '0;
      rsp_div0_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_op_q    <= cur_op_d;
      cfg_known_q <= cfg_known_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      rsp_data_q  <= rsp_data_d;
      rsp_op_q    <= rsp_op_d;
      rsp_div0_q  <= rsp_div0_d;
    end
  end

  // Next-state logic: accept, optional config write, execute, respond
  always_comb begin
    state_d     = state_q;
    cur_op_d    = cur_op_q;
    cfg_known_d = cfg_known_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    rsp_data_d  = rsp_data_q;
    rsp_op_d    = rsp_op_q;
    rsp_div0_d  = rsp_div0_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d = bus.cmd_op;
          a_d  = bus.cmd_a;
          b_d  = bus.cmd_b;
          if (bus.cmd_op == OP_DIV && bus.cmd_b == '0) begin
            // Answer locally; the ALU and its opcode shadow stay as they are
            rsp_data_d = '1;
            rsp_div0_d = 1'b1;
            rsp_op_d   = OP_DIV;
            state_d    = RESP;
          end else if (!cfg_known_q || bus.cmd_op != cur_op_q) begin
            state_d = CONFIG;
          end else begin
            state_d = EXEC;
          end
        end
      end
      CONFIG: begin
        cur_op_d    = op_q;
        cfg_known_d = 1'b1;
        state_d     = EXEC;
      end
      EXEC: begin
        rsp_data_d = alu_c;
        rsp_op_d   = op_q;
        rsp_div0_d = 1'b0;
        state_d    = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and ALU-side outputs are pure decodes of the registered state
  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_op      = rsp_op_q;
  assign bus.rsp_div0    = rsp_div0_q;
  assign alu_config_en   = (state_q == CONFIG);
  assign alu_config_data = (state_q == CONFIG) ? op_q : cur_op_q;
  assign alu_a           = a_q;
  assign alu_b           = b_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: a simple ALU with its own opcode
// register, a transaction-level expectation model, and directed commands.
module tb_alu_cmd_sequencer;
  localparam int W  = 16;
  localparam int OW = 2;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  alu_cmd_sequencer_if #(.WIDTH(W), .OPW(OW)) bus();

  logic [W-1:0]  alu_a, alu_b, alu_c;
  logic [OW-1:0] alu_config_data;
  logic          alu_config_en;

  alu_cmd_sequencer #(.WIDTH(W), .OPW(OW)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .bus             (bus),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_config_data (alu_config_data),
    .alu_config_en   (alu_config_en),
    .alu_c           (alu_c)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [W-1:0] arith(input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a * b;
      default: return (b == '0) ? '1 : a / b;
    endcase
  endfunction

  // ALU: opcode register written by the sequencer, combinational result
  logic [OW-1:0] alu_reg = '0;
  always @(posedge CLK) if (alu_config_en) alu_reg <= alu_config_data;
  assign alu_c = arith(alu_reg, alu_a, alu_b);

  // Transaction model: one command in flight, latency by config need / div0
  bit            m_busy = 1'b0, m_cfg = 1'b0, m_div0 = 1'b0, m_known = 1'b0;
  int            m_age = 0, m_lat = 0;
  logic [OW-1:0] m_op = '0, m_cur = '0;
  logic [W-1:0]  m_a = '0, m_b = '0, m_data = '0;

  always @(posedge CLK) begin
    if (RESET) begin
      m_busy = 1'b0; m_known = 1'b0; m_cur = '0;
    end else if (m_busy) begin
      if (m_age >= m_lat && bus.rsp_ready) m_busy = 1'b0;
      else if (m_age < m_lat) m_age++;
    end else if (bus.cmd_valid) begin
      m_busy = 1'b1; m_age = 1;
      m_op = bus.cmd_op; m_a = bus.cmd_a; m_b = bus.cmd_b;
      m_div0 = (bus.cmd_op == 2'd3) && (bus.cmd_b == '0);
      if (m_div0) begin
        m_cfg = 1'b0; m_lat = 1; m_data = '1;
      end else begin
        m_cfg = !m_known || (bus.cmd_op != m_cur);
        m_lat = m_cfg ? 3 : 2;
        m_data = arith(bus.cmd_op, bus.cmd_a, bus.cmd_b);
        m_known = 1'b1; m_cur = bus.cmd_op;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    bit exp_rv, exp_en;
    exp_rv = m_busy && (m_age >= m_lat);
    exp_en = m_busy && m_cfg && (m_age == 1);
    check("cmd_ready", 32'(bus.cmd_ready), 32'(!m_busy));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
    check("cfg_en", 32'(alu_config_en), 32'(exp_en));
    check("cfg_data", 32'(alu_config_data), 32'(exp_en ? m_op : m_cur));
    if (exp_rv) begin
      check("rsp_data", 32'(bus.rsp_data), 32'(m_data));
      check("rsp_op", 32'(bus.rsp_op), 32'(m_op));
      check("rsp_div0", 32'(bus.rsp_div0), 32'(m_div0));
    end
    if (m_busy && !m_div0) begin
      check("alu_a", 32'(alu_a), 32'(m_a));
      check("alu_b", 32'(alu_b), 32'(m_b));
    end
  endtask

  task automatic do_cmd(input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_data, input logic exp_div0,
                        input int exp_lat, input int exp_cfg, input int hold);
    int n, cyc, cfgs;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin @(negedge CLK); n++; end
    check("wait_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
    @(posedge CLK);
    @(negedge CLK);
    // Scramble inputs after accept: they must be ignored
    bus.cmd_valid = 1'b0; bus.cmd_op = ~op;
    bus.cmd_a = 16'($urandom); bus.cmd_b = 16'($urandom);
    cyc = 1; cfgs = 0;
    while (!bus.rsp_valid && cyc < 10) begin
      if (alu_config_en) cfgs++;
      @(negedge CLK);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(exp_lat));
    check("cfg_pulses", 32'(cfgs), 32'(exp_cfg));
    for (int i = 0; i < hold; i++) begin
      check("hold_data", 32'(bus.rsp_data), 32'(exp_data));
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      @(negedge CLK);
    end
    check("rsp_data_lit", 32'(bus.rsp_data), 32'(exp_data));
    check("rsp_op_lit", 32'(bus.rsp_op), 32'(op));
    check("rsp_div0_lit", 32'(bus.rsp_div0), 32'(exp_div0));
    bus.rsp_ready = 1'b1;
    @(negedge CLK);
    bus.rsp_ready = 1'b0;
    check("ready_after_rsp", 32'(bus.cmd_ready), 32'd1);
    $display("txn op=%0d a=%04h b=%04h -> data=%04h div0=%0b lat=%0d cfg=%0d",
             op, a, b, exp_data, exp_div0, cyc, cfgs);
  endtask

  initial begin
    RESET = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    // Per-cycle comparison against the model whenever reset is released
    fork
      forever begin
        @(negedge CLK);
        if (!RESET) compare_cycle();
      end
    join_none

    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_cfg_en", 32'(alu_config_en), 32'd0);
    check("rst_cfg_data", 32'(alu_config_data), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst_rsp_div0", 32'(bus.rsp_div0), 32'd0);
    @(negedge CLK);

    //      op    a         b         exp       div0  lat cfg hold
    do_cmd(2'd0, 16'd3,    16'd4,    16'd7,    1'b0, 3, 1, 0);
    do_cmd(2'd0, 16'hFFFF, 16'd2,    16'h0001, 1'b0, 2, 0, 0);
    do_cmd(2'd1, 16'd5,    16'd7,    16'hFFFE, 1'b0, 3, 1, 0);
    do_cmd(2'd2, 16'h0100, 16'h0100, 16'h0000, 1'b0, 3, 1, 0);
    do_cmd(2'd3, 16'd100,  16'd7,    16'd14,   1'b0, 3, 1, 0);
    do_cmd(2'd3, 16'd9,    16'd0,    16'hFFFF, 1'b1, 1, 0, 0);
    do_cmd(2'd3, 16'd9,    16'd3,    16'd3,    1'b0, 2, 0, 5);

    // Reset during the EXEC cycle of an op=2 command
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2; bus.cmd_a = 16'd3; bus.cmd_b = 16'd5;
    @(posedge CLK);
    @(negedge CLK);
    bus.cmd_valid = 1'b0;
    check("abort_cfg_en", 32'(alu_config_en), 32'd1);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
      check("abort_ready", 32'(bus.cmd_ready), 32'd1);
      @(negedge CLK);
    end
    $display("txn op=2 aborted by reset in EXEC");

    do_cmd(2'd2, 16'd6,    16'd7,    16'd42,   1'b0, 3, 1, 0);
    do_cmd(2'd1, 16'd10,   16'd3,    16'd7,    1'b0, 3, 1, 0);

    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
